// File: rtl/stack_seq_ctrl_pkg.sv
// Shared constants and state encoding for the interrupt-entry / RTI stack sequencer.
package stack_seq_ctrl_pkg;

    localparam logic [3:0] OP_PUSH_POP = 4'd7;
    localparam logic [3:0] OP_CALL     = 4'd11;
    localparam logic [3:0] OP_LD_ST_I  = 4'd12;

    // ra_brx sub-decode of OP_CALL
    localparam logic [1:0] BRX_CALL = 2'd1;
    localparam logic [1:0] BRX_RET  = 2'd2;
    localparam logic [1:0] BRX_RTI  = 2'd3;

    localparam logic [1:0] SP_REG_IDX       = 2'd3;
    localparam logic [7:0] INT_VEC_ADDR_DEF = 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        INT_PUSH_PC,
        INT_PUSH_FLG,
        INT_VEC,
        RTI_POP_FLG,
        RTI_POP_PC
    } state_t;

endpackage

// File: rtl/stack_seq_ctrl.sv
// Multi-cycle sequencer owning the data-memory port and R3 during interrupt entry and RTI.
// Pushes PC and flags on interrupt and loads the vector; RTI pops flags then PC.
module stack_seq_ctrl
    import stack_seq_ctrl_pkg::*;
#(
    parameter int                  DATA_W       = 8,
    parameter logic [DATA_W-1:0]   INT_VEC_ADDR = DATA_W'(INT_VEC_ADDR_DEF),
    parameter int                  FLAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              intr_req,
    input  logic              op_valid,
    input  logic [3:0]        opcode,
    input  logic [1:0]        ra_brx,
    input  logic [DATA_W-1:0] pc_ret,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [DATA_W-1:0] sp_in,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sp_we,
    output logic [DATA_W-1:0] sp_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata,
    output logic              flags_we,
    output logic [FLAG_W-1:0] flags_wdata,
    output logic              stall,
    output logic              intr_ack,
    output logic              busy
);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   sp_reg, sp_next;
    logic                int_pend_reg, int_pend_next;
    logic                intr_q_reg;
    logic                is_rti;
    logic                start;
    logic [DATA_W-1:0]   sp_dec, sp_inc;

    assign is_rti = op_valid && (opcode == OP_CALL) && (ra_brx == BRX_RTI);
    // Wraps modulo 2^DATA_W by construction
    assign sp_dec = sp_reg - DATA_W'(1);
    assign sp_inc = sp_reg + DATA_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sp_reg       <= '0;
            int_pend_reg <= 1'b0;
            intr_q_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sp_reg       <= sp_next;
            int_pend_reg <= int_pend_next;
            intr_q_reg   <= intr_req;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sp_next     = sp_reg;
        start       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        sp_we       = 1'b0;
        sp_wdata    = '0;
        pc_we       = 1'b0;
        pc_wdata    = '0;
        flags_we    = 1'b0;
        flags_wdata = '0;
        intr_ack    = 1'b0;

        case (state_reg)
            IDLE: begin
                // RTI wins; a pending interrupt is taken on the next IDLE visit
                if (is_rti) begin
                    start      = 1'b1;
                    sp_next    = sp_in;
                    state_next = RTI_POP_FLG;
                end else if (int_pend_reg) begin
                    start      = 1'b1;
                    sp_next    = sp_in;
                    state_next = INT_PUSH_PC;
                end
            end
            INT_PUSH_PC: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_reg;
                mem_wdata = pc_ret;
                if (mem_gnt) begin
                    sp_we      = 1'b1;
                    sp_wdata   = sp_dec;
                    sp_next    = sp_dec;
                    state_next = INT_PUSH_FLG;
                end
            end
            INT_PUSH_FLG: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_reg;
                mem_wdata = DATA_W'(flags_in);
                if (mem_gnt) begin
                    sp_we      = 1'b1;
                    sp_wdata   = sp_dec;
                    sp_next    = sp_dec;
                    state_next = INT_VEC;
                end
            end
            INT_VEC: begin
                mem_req  = 1'b1;
                mem_addr = INT_VEC_ADDR;
                if (mem_gnt) begin
                    pc_we      = 1'b1;
                    pc_wdata   = mem_rdata;
                    intr_ack   = 1'b1;
                    state_next = IDLE;
                end
            end
            RTI_POP_FLG: begin
                mem_req  = 1'b1;
                mem_addr = sp_inc;
                if (mem_gnt) begin
                    sp_we       = 1'b1;
                    sp_wdata    = sp_inc;
                    sp_next     = sp_inc;
                    flags_we    = 1'b1;
                    flags_wdata = mem_rdata[FLAG_W-1:0];
                    state_next  = RTI_POP_PC;
                end
            end
            RTI_POP_PC: begin
                mem_req  = 1'b1;
                mem_addr = sp_inc;
                if (mem_gnt) begin
                    sp_we      = 1'b1;
                    sp_wdata   = sp_inc;
                    sp_next    = sp_inc;
                    pc_we      = 1'b1;
                    pc_wdata   = mem_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh edge always survives, even one landing while the sequencer is busy
        int_pend_next = (int_pend_reg && !((state_reg == IDLE) && (state_next == INT_PUSH_PC)))
                      || (intr_req && !intr_q_reg);

        busy  = (state_reg != IDLE);
        stall = busy || start;
    end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed self-checking bench for stack_seq_ctrl with a small behavioural data memory.
module tb_stack_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       intr_req;
    logic       op_valid;
    logic [3:0] opcode;
    logic [1:0] ra_brx;
    logic [7:0] pc_ret;
    logic [3:0] flags_in;
    logic [7:0] sp_in;
    logic       mem_gnt;
    logic [7:0] mem_rdata;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       sp_we;
    logic [7:0] sp_wdata;
    logic       pc_we;
    logic [7:0] pc_wdata;
    logic       flags_we;
    logic [3:0] flags_wdata;
    logic       stall, intr_ack, busy;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    stack_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .intr_req(intr_req), .op_valid(op_valid),
        .opcode(opcode), .ra_brx(ra_brx), .pc_ret(pc_ret), .flags_in(flags_in),
        .sp_in(sp_in), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp_we(sp_we), .sp_wdata(sp_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata),
        .flags_we(flags_we), .flags_wdata(flags_wdata), .stall(stall),
        .intr_ack(intr_ack), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one cycle's outputs (data fields only where their strobe is expected),
    // applies any granted write to the memory model, then advances to just after the next edge.
    task automatic cyc(input string tag, input bit req, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input bit spwe, input logic [7:0] spwd,
                       input bit pcwe, input logic [7:0] pcwd, input bit fwe,
                       input logic [3:0] fwd, input bit ack, input bit stall_e, input bit busy_e);
        #1;
        check({tag, ".req"}, 32'(mem_req), 32'(req));
        check({tag, ".we"}, 32'(mem_we), 32'(we));
        if (req) check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        if (req && we) check({tag, ".wdata"}, 32'(mem_wdata), 32'(wdata));
        check({tag, ".sp_we"}, 32'(sp_we), 32'(spwe));
        if (spwe) check({tag, ".sp_wdata"}, 32'(sp_wdata), 32'(spwd));
        check({tag, ".pc_we"}, 32'(pc_we), 32'(pcwe));
        if (pcwe) check({tag, ".pc_wdata"}, 32'(pc_wdata), 32'(pcwd));
        check({tag, ".flags_we"}, 32'(flags_we), 32'(fwe));
        if (fwe) check({tag, ".flags_wdata"}, 32'(flags_wdata), 32'(fwd));
        check({tag, ".ack"}, 32'(intr_ack), 32'(ack));
        check({tag, ".stall"}, 32'(stall), 32'(stall_e));
        check({tag, ".busy"}, 32'(busy), 32'(busy_e));
        $display("cycle %s: req=%0b we=%0b addr=%02h wdata=%02h sp_we=%0b sp=%02h pc_we=%0b pc=%02h f_we=%0b f=%0h ack=%0b",
                 tag, mem_req, mem_we, mem_addr, mem_wdata, sp_we, sp_wdata, pc_we, pc_wdata,
                 flags_we, flags_wdata, intr_ack);
        if (mem_req && mem_we && mem_gnt) mem[mem_addr] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input bit stall_e);
        cyc(tag, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 4'h0, 0, stall_e, 0);
    endtask

    // One sequencer state held for nwait ungranted cycles, then granted once.
    task automatic st(input string tag, input int nwait, input bit we, input logic [7:0] addr,
                      input logic [7:0] wdata, input bit spwe, input logic [7:0] spwd,
                      input bit pcwe, input logic [7:0] pcwd, input bit fwe,
                      input logic [3:0] fwd, input bit ack);
        for (int w = 0; w <= nwait; w++) begin
            bit g;
            g = (w == nwait);
            mem_gnt = g;
            cyc(tag, 1, we, addr, wdata, spwe && g, spwd, pcwe && g, pcwd, fwe && g, fwd,
                ack && g, 1, 1);
        end
        mem_gnt = 1'b1;
    endtask

    task automatic interrupt_seq(input string tag, input int nwait, input logic [7:0] sp0,
                                 input logic [7:0] pcv, input logic [3:0] fl, input logic [7:0] vec);
        logic [7:0] sp1, sp2;
        sp1 = sp0 - 8'd1;
        sp2 = sp0 - 8'd2;
        st({tag, "_pushpc"}, nwait, 1, sp0, pcv, 1, sp1, 0, 8'h00, 0, 4'h0, 0);
        st({tag, "_pushflg"}, nwait, 1, sp1, {4'h0, fl}, 1, sp2, 0, 8'h00, 0, 4'h0, 0);
        st({tag, "_vec"}, nwait, 0, 8'h01, 8'h00, 0, 8'h00, 1, vec, 0, 4'h0, 1);
    endtask

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1]   = 8'h40;
        rst_n    = 1'b0;
        intr_req = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'd0;
        ra_brx   = 2'd0;
        pc_ret   = 8'h20;
        flags_in = 4'b0101;
        sp_in    = 8'hFF;
        mem_gnt  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        idle("reset", 0);

        // Interrupt with grant always high
        intr_req = 1'b1;
        idle("s1_detect", 0);
        idle("s1_start", 1);
        interrupt_seq("s1", 0, 8'hFF, 8'h20, 4'b0101, 8'h40);
        idle("s1_done", 0);
        a = 8'hFF; check("s1_mem_ff", 32'(mem[a]), 32'h20);
        a = 8'hFE; check("s1_mem_fe", 32'(mem[a]), 32'h05);

        // RTI with grant always high
        intr_req = 1'b0;
        sp_in    = 8'hFD;
        op_valid = 1'b1; opcode = 4'd11; ra_brx = 2'd3;
        idle("s2_start", 1);
        op_valid = 1'b0;
        st("s2_popflg", 0, 0, 8'hFE, 8'h00, 1, 8'hFE, 0, 8'h00, 1, 4'b0101, 0);
        st("s2_poppc", 0, 0, 8'hFF, 8'h00, 1, 8'hFF, 1, 8'h20, 0, 4'h0, 0);
        idle("s2_done", 0);

        // CALL/RET encodings are ignored
        op_valid = 1'b1; opcode = 4'd11; ra_brx = 2'd2;
        idle("ret_ignored", 0);
        op_valid = 1'b0;

        // Interrupt with three wait cycles in every state
        mem[8'hFF] = 8'h00; mem[8'hFE] = 8'h00;
        sp_in = 8'hFF;
        intr_req = 1'b1;
        idle("s3_detect", 0);
        idle("s3_start", 1);
        interrupt_seq("s3", 3, 8'hFF, 8'h20, 4'b0101, 8'h40);
        idle("s3_done", 0);
        a = 8'hFF; check("s3_mem_ff", 32'(mem[a]), 32'h20);
        a = 8'hFE; check("s3_mem_fe", 32'(mem[a]), 32'h05);

        // RTI concurrent with an interrupt edge: RTI first, then the interrupt
        intr_req = 1'b0;
        idle("s4_low", 0);
        sp_in    = 8'hFD;
        intr_req = 1'b1;
        op_valid = 1'b1; opcode = 4'd11; ra_brx = 2'd3;
        idle("s4_start", 1);
        op_valid = 1'b0;
        st("s4_popflg", 0, 0, 8'hFE, 8'h00, 1, 8'hFE, 0, 8'h00, 1, 4'b0101, 0);
        st("s4_poppc", 0, 0, 8'hFF, 8'h00, 1, 8'hFF, 1, 8'h20, 0, 4'h0, 0);
        sp_in = 8'hFF;
        idle("s4_int_start", 1);
        interrupt_seq("s4", 0, 8'hFF, 8'h20, 4'b0101, 8'h40);
        idle("s4_done", 0);

        // SP wrap on push (00 -> FF -> FE) and pop (FF -> 00 -> 01)
        intr_req = 1'b0;
        idle("s5_low", 0);
        sp_in    = 8'h00;
        pc_ret   = 8'h2A;
        intr_req = 1'b1;
        idle("s5_detect", 0);
        idle("s5_start", 1);
        interrupt_seq("s5", 0, 8'h00, 8'h2A, 4'b0101, 8'h40);
        idle("s5_done", 0);
        sp_in = 8'hFF;
        op_valid = 1'b1; opcode = 4'd11; ra_brx = 2'd3;
        idle("s5r_start", 1);
        op_valid = 1'b0;
        st("s5r_popflg", 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 4'hA, 0);
        st("s5r_poppc", 0, 0, 8'h01, 8'h00, 1, 8'h01, 1, 8'h40, 0, 4'h0, 0);
        idle("s5r_done", 0);

        // Reset asserted in INT_PUSH_FLG aborts the sequence
        intr_req = 1'b0;
        pc_ret   = 8'h20;
        sp_in    = 8'hFF;
        idle("s6_low", 0);
        intr_req = 1'b1;
        idle("s6_detect", 0);
        idle("s6_start", 1);
        st("s6_pushpc", 0, 1, 8'hFF, 8'h20, 1, 8'hFE, 0, 8'h00, 0, 4'h0, 0);
        mem_gnt  = 1'b0;
        rst_n    = 1'b0;
        intr_req = 1'b0;
        cyc("s6_rst", 1, 1, 8'hFE, 8'h05, 0, 8'h00, 0, 8'h00, 0, 4'h0, 0, 1, 1);
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        idle("s6_after1", 0);
        idle("s6_after2", 0);
        idle("s6_after3", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
Multi-cycle sequencer for interrupt entry and RTI. It drives the data-memory port, the SP (R3) write port of the register file, PC and flags.
- Sits beside the decode control unit and stalls the pipeline while it owns memory and R3.
- Interrupt entry: push PC, push flags, load PC from M[INT_VEC_ADDR].
- RTI: pop flags, then pop PC.

Parameters:
DATA_W, 8, data/address width (ISA is 8-bit)
INT_VEC_ADDR, 8'd1, memory address holding the interrupt vector
FLAG_W, 4, flag register width (Z,N,C,V); zero-extended to DATA_W when pushed

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
intr_req  in  1  external interrupt request (level; rising edge latched)
op_valid  in  1  decoded instruction in EX is valid
opcode  in  4  IR[7:4] of EX instruction
ra_brx  in  2  IR[3:2] of EX instruction
pc_ret  in  DATA_W  PC to resume at (next unexecuted instruction)
flags_in  in  FLAG_W  current CCR
sp_in  in  DATA_W  current R3 value
mem_gnt  in  1  memory port granted; access completes this cycle
mem_rdata  in  DATA_W  read data, valid in the mem_gnt cycle
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read
mem_addr  out  DATA_W  access address
mem_wdata  out  DATA_W  write data
sp_we  out  1  write R3 (forces SD1=1 path)
sp_wdata  out  DATA_W  new SP
pc_we  out  1  load PC
pc_wdata  out  DATA_W  new PC
flags_we  out  1  load CCR
flags_wdata  out  FLAG_W  new CCR
stall  out  1  freeze fetch/decode/EX
intr_ack  out  1  one-cycle pulse when the vector is loaded
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, INT_PUSH_PC, INT_PUSH_FLG, INT_VEC, RTI_POP_FLG, RTI_POP_PC.
- Reset (rst_n=0 at edge):
  - state=IDLE; int_pend=0; sp_q=0; intr_q=0.
  - All outputs are 0 while in IDLE with no start condition.
  - Reset mid-sequence aborts immediately and performs no further writes.
- Edge latch:
  - intr_q <= intr_req.
  - int_pend sets on intr_req & ~intr_q.
  - int_pend clears on the transition into INT_PUSH_PC.
  - An edge that arrives while busy is kept pending.
- RTI decode: op_valid & opcode==11 & ra_brx==3.
- IDLE transitions:
  - If RTI: go to RTI_POP_FLG. RTI has priority over a pending interrupt, which is taken after return to IDLE.
  - Else if int_pend: go to INT_PUSH_PC.
  - On either start, sp_q <= sp_in and stall=1 in that same IDLE cycle.
- Push (X[SP--]):
  - mem_req=1, mem_we=1, mem_addr=sp_q.
  - On mem_gnt: sp_we=1, sp_wdata=sp_q-1, sp_q<=sp_q-1.
- Pop (X[++SP]):
  - mem_req=1, mem_we=0, mem_addr=sp_q+1.
  - On mem_gnt: sp_we=1, sp_wdata=sp_q+1, sp_q<=sp_q+1.
- Per-state actions:
  - INT_PUSH_PC: push pc_ret -> INT_PUSH_FLG.
  - INT_PUSH_FLG: push {0,flags_in} -> INT_VEC.
  - INT_VEC: read INT_VEC_ADDR, no SP change. On gnt: pc_we=1, pc_wdata=mem_rdata, intr_ack=1 -> IDLE.
  - RTI_POP_FLG: on gnt, flags_we=1, flags_wdata=mem_rdata[FLAG_W-1:0] -> RTI_POP_PC.
  - RTI_POP_PC: on gnt, pc_we=1, pc_wdata=mem_rdata -> IDLE.
- mem_gnt=0: hold state; mem_* outputs stay stable; no sp/pc/flags writes.
- Strobes: sp_we, pc_we, flags_we and intr_ack are combinational from state & mem_gnt, and last exactly one cycle per grant.
- SP arithmetic is modulo 2^DATA_W: 0-1=255, 255+1=0. No overflow flag.
- stall = busy | start_condition. busy = (state != IDLE).
- Latency with mem_gnt tied 1:
  - Interrupt: 3 busy cycles after the detect cycle; PC is loaded in the 3rd.
  - RTI: 2 busy cycles.
- Opcode 11 with brx=1/2 (CALL/RET) and opcode 7 (PUSH/POP) are not handled here; they stay single-cycle in the pipeline.

Decomposition:
- Shared package:
  - opcode constants OP_PUSH_POP=7, OP_CALL=11, OP_LD_ST_I=12;
  - brx constants BRX_CALL/RET/RTI;
  - SP_REG_IDX=3;
  - state enum;
  - INT_VEC_ADDR default.
- No sub-module is needed. The FSM, edge latch and SP shadow fit in one module.

Test Plan:
- Interrupt, gnt=1: sp_in=8'hFF, pc_ret=8'h20, flags=4'b0101, M[1]=8'h40 -> M[FF]=20, M[FE]=05, SP writes FE then FD, pc_wdata=40, intr_ack at cycle 3, stall for 4 cycles.
- RTI, gnt=1: sp_in=8'hFD, M[FE]=05, M[FF]=20 -> flags_wdata=0101, then pc_wdata=20, SP writes FE then FF.
- Wait states: interrupt with mem_gnt low for 3 cycles in each state -> outputs held, no sp_we, same final values as the first scenario.
- Simultaneous RTI and intr_req edge -> RTI completes first, then INT_PUSH_PC starts the next cycle with the updated sp_in.
- Wrap: interrupt with sp_in=8'h00 -> pushes to 00 then FF, sp_wdata FF then FE. RTI with sp_in=8'hFF -> reads 00 then 01.
- Reset mid-sequence: rst_n=0 in INT_PUSH_FLG -> next cycle IDLE, int_pend=0, no pc_we and no intr_ack.
